// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants, glyph table and scan state encoding
package seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bus is active-low with segment a in the MSB down to g in the LSB
  localparam int SEG_A_BIT = 6;
  localparam int SEG_G_BIT = 0;
  localparam int SEG_WIDTH = SEG_A_BIT - SEG_G_BIT + 1;

  localparam logic [SEG_WIDTH-1:0]  SEG_BLANK = '1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Index 15 (F) first so GLYPH_TABLE[n] yields the glyph for nibble n
  localparam logic [15:0][SEG_WIDTH-1:0] GLYPH_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display value update handshake (valid/ready)
interface seg_scan_ctrl_if;
  import seg_scan_ctrl_pkg::*;

  logic                      upd_valid;
  logic [4*NUM_DIGITS-1:0]   upd_data;
  logic [NUM_DIGITS-1:0]     upd_dp;
  logic                      upd_ready;

  modport master (output upd_valid, upd_data, upd_dp, input upd_ready);
  modport slave  (input upd_valid, upd_data, upd_dp, output upd_ready);

endinterface

// File: rtl/seg_hex_glyph.sv
// rtl/seg_hex_glyph.sv - combinational hex nibble to active-low 7-segment glyph
module seg_hex_glyph
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0]           nibble,
  output logic [SEG_WIDTH-1:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scanner with frame-synchronous updates
// Optional SEG_LZ_BLANK_EN: leading-zero digits 3..1 stay dark during DRIVE.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned GUARD   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        upd,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_WIDTH-1:0]  seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned DRIVE_LEN = CLK_DIV - GUARD;
  localparam int          CW        = $clog2(CLK_DIV);

  scan_state_e           state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [1:0]            idx, idx_nxt;
  logic [15:0]           disp_data, pend_data;
  logic [NUM_DIGITS-1:0] disp_dp, pend_dp;
  logic                  pend_full;
  logic                  xfer, commit, blank_digit;
  logic [3:0]            nibble;
  logic [SEG_WIDTH-1:0]  glyph, seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  dp_nxt;

  // The commit cycle (frame_tick high) also keeps ready low for one cycle
  assign upd.upd_ready = ~rst & ~pend_full & ~frame_tick;
  assign xfer          = upd.upd_valid & upd.upd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_GUARD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (enable) begin
      if (state == ST_GUARD) begin
        if (cnt == CW'(GUARD - 1)) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end else begin
        if (cnt == CW'(DRIVE_LEN - 1)) begin
          state_nxt = ST_GUARD;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  assign commit = enable && (state == ST_DRIVE) && (cnt == CW'(DRIVE_LEN - 1))
                  && (idx == 2'(NUM_DIGITS - 1)) && pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= commit;
      if (commit) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pend_full <= 1'b0;
      end else if (xfer) begin
        pend_data <= upd.upd_data;
        pend_dp   <= upd.upd_dp;
        pend_full <= 1'b1;
      end
    end
  end

  assign nibble = disp_data[{idx_nxt, 2'b00} +: 4];

  seg_hex_glyph u_glyph (
    .nibble (nibble),
    .glyph  (glyph)
  );

`ifdef SEG_LZ_BLANK_EN
  assign blank_digit = (idx_nxt != 2'd0) && ((disp_data >> {idx_nxt, 2'b00}) == 16'd0);
`else
  assign blank_digit = 1'b0;
`endif

  // Outputs are computed from the next state so they switch on the same edge
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (enable && (state_nxt == ST_DRIVE) && !blank_digit) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_nxt = glyph;
      dp_nxt  = ~disp_dp[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (CLK_DIV=8, GUARD=2)
module tb_seg_scan_ctrl;

  localparam int CLK_DIV_C = 8;
  localparam int GUARD_C   = 2;
  localparam int FRAME     = 4 * CLK_DIV_C;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif
  localparam logic [3:0][3:0] AN_STD = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic       clk = 1'b0;
  logic       rst, enable, dp, frame_tick;
  logic [3:0] an;
  logic [6:0] seg;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV_C), .GUARD(GUARD_C)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .upd        (bus),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dpb;
    logic [3:0][3:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dpo;
  } vec_t;
  vec_t vecs [5];

  int          total = 0;
  int          bad   = 0;
  int          m_pos;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpb, m_pdp, m_an;
  logic [6:0]  m_seg;
  logic        m_dp, m_pfull, m_ftick;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scan position counts enabled cycles within a 32-cycle frame
  task automatic model_step();
    bit         xfer, commit;
    int         d;
    logic [3:0] nib;
    if (rst) begin
      m_pos = 0; m_disp = '0; m_dpb = '0; m_pfull = 1'b0; m_ftick = 1'b0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      xfer   = bus.upd_valid && !m_pfull && !m_ftick;
      commit = 1'b0;
      if (enable) begin
        m_pos  = (m_pos + 1) % FRAME;
        commit = (m_pos == 0) && m_pfull;
      end
      m_ftick = commit;
      if (commit) begin
        m_disp = m_pend; m_dpb = m_pdp; m_pfull = 1'b0;
      end else if (xfer) begin
        m_pend = bus.upd_data; m_pdp = bus.upd_dp; m_pfull = 1'b1;
      end
      d   = m_pos / CLK_DIV_C;
      nib = m_disp[4*d +: 4];
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      if (enable && (m_pos % CLK_DIV_C) >= GUARD_C && !(LZ_EN && d > 0 && (m_disp >> (4*d)) == 16'd0)) begin
        m_an[d] = 1'b0;
        m_seg   = glyph_tab[nib];
        m_dp    = !m_dpb[d];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", {an, seg, dp, frame_tick, bus.upd_ready},
          {m_an, m_seg, m_dp, m_ftick, !rst && !m_pfull && !m_ftick});
  endtask

  task automatic offer(logic [15:0] d, logic [3:0] p);
    bit ok = 1'b0;
    bus.upd_valid = 1'b1; bus.upd_data = d; bus.upd_dp = p;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      ok = (bus.upd_ready === 1'b1);
      tick();
    end
    bus.upd_valid = 1'b0;
    check("offer_accept", ok, 1);
  endtask

  task automatic wait_ftick();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (m_ftick) break;
    end
    check("frame_tick", frame_tick, 1);
  endtask

  task automatic tick_to_pos(int p);
    for (int i = 0; i < 2 * FRAME && m_pos != p; i++) tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; enable = 1'b1;
    bus.upd_valid = 1'b0; bus.upd_data = '0; bus.upd_dp = '0;

    vecs[0] = '{16'h1234, 4'b0001, AN_STD,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1110};
    vecs[1] = '{16'h89AB, 4'b1000, AN_STD,
                {7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000}, 4'b0111};
    vecs[2] = '{16'hCDEF, 4'b0110, AN_STD,
                {7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000}, 4'b1001};
    vecs[3] = '{16'h5670, 4'b0000, AN_STD,
                {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000001}, 4'b1111};
`ifdef SEG_LZ_BLANK_EN
    vecs[4] = '{16'h0050, 4'b0100, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1111};
`else
    vecs[4] = '{16'h0050, 4'b0100, AN_STD,
                {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1011};
`endif

    repeat (3) tick();
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_ready", bus.upd_ready, 0);
    check("rst_frame_tick", frame_tick, 0);
    rst = 1'b0;
    tick();
    check("ready_after_release", bus.upd_ready, 1);

    for (int r = 0; r < 5; r++) begin
      offer(vecs[r].data, vecs[r].dpb);
      wait_ftick();
      for (int i = 1; i < FRAME; i++) begin
        tick();
        if (m_pos % CLK_DIV_C == 4) begin
          check($sformatf("vec%0d_d%0d_an", r, m_pos / CLK_DIV_C), an, vecs[r].an[m_pos / CLK_DIV_C]);
          check($sformatf("vec%0d_d%0d_seg", r, m_pos / CLK_DIV_C), seg, vecs[r].seg[m_pos / CLK_DIV_C]);
          check($sformatf("vec%0d_d%0d_dp", r, m_pos / CLK_DIV_C), dp, vecs[r].dpo[m_pos / CLK_DIV_C]);
        end
      end
    end

    // Second value offered while the first is still pending
    offer(16'hAAAA, 4'h0);
    bus.upd_valid = 1'b1; bus.upd_data = 16'hBEEF; bus.upd_dp = 4'h0;
    wait_ftick();
    check("commit_ready_low", bus.upd_ready, 0);
    tick();
    check("ready_rise", bus.upd_ready, 1);
    tick();
    check("ready_fall", bus.upd_ready, 0);
    bus.upd_valid = 1'b0;
    tick_to_pos(27);
    check("frame_a_d3", seg, 7'b0001000);
    wait_ftick();
    tick_to_pos(27);
    check("frame_b_d3", seg, 7'b1100000);
    tick_to_pos(11);
    check("frame_b_d1", seg, 7'b0110000);

    // Pause in the middle of digit 2 DRIVE
    tick_to_pos(21);
    check("pause_pre_an", an, 4'b1011);
    enable = 1'b0;
    repeat (5) begin
      tick();
      check("pause_an", an, 4'hF);
    end
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (an !== 4'b1011) break;
      cnt++;
    end
    check("resume_drive_cycles", cnt, 2);

    // Reset during digit 3 DRIVE with a pending value
    offer(16'h9999, 4'hF);
    tick_to_pos(27);
    check("pend_full_ready", bus.upd_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_midrst", bus.upd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt += int'(frame_tick);
      if (m_pos == 4) begin
        check("midrst_d0_an", an, 4'b1110);
        check("midrst_d0_seg", seg, 7'b0000001);
      end
    end
    check("no_commit_after_rst", cnt, 0);

    for (int i = 0; i < 800; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      bus.upd_valid = ($urandom_range(0, 3) == 0);
      bus.upd_data  = 16'($urandom);
      bus.upd_dp    = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
